// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and request bundle.
// Used by alu_req_queue, alu_req_mem and the ALU itself.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef struct packed {
    logic [63:0] in1;
    logic [63:0] in2;
    logic [2:0]  op;
  } alu_req_t;

  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): ok = 1'b1;
      (op == OP_SUB): ok = 1'b1;
      (op == OP_XOR): ok = 1'b1;
      (op == OP_AND): ok = 1'b1;
      (op == OP_OR):  ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_req_mem.sv
// Request storage for alu_req_queue: register array,
// sync write, async read, synchronous clear on reset.
module alu_req_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  alu_req_t      wdata,
  input  logic [AW-1:0] raddr,
  output alu_req_t      rdata
);

  alu_req_t mem [DEPTH];

  // clear all entries on reset, else write the tail entry
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_req_queue.sv
// Request FIFO in front of the 64-bit ALU; drops illegal ops.
// Optional ALU_REQ_BYPASS_EN: zero-latency path when empty.
module alu_req_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_in1,
  input  logic [63:0]              req_in2,
  input  logic [2:0]               req_op,
  output logic [63:0]              alu_in1,
  output logic [63:0]              alu_in2,
  output logic [2:0]               alu_op,
  output logic                     alu_in_valid,
  input  logic                     alu_in_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CNT_W-1:0] drops;
  logic             legal;
  logic             accept;
  logic             not_empty;
  logic             byp;
  logic             push;
  logic             pop;
  alu_req_t         req;
  alu_req_t         head;

  assign req       = '{in1: req_in1, in2: req_in2, op: req_op};
  assign legal     = op_legal(req_op);
  assign not_empty = (cnt != '0);
  assign req_ready = (cnt != CW'(DEPTH));
  assign accept    = req_valid & req_ready;

`ifdef ALU_REQ_BYPASS_EN
  assign byp = ~not_empty & req_valid & legal;
`else
  assign byp = 1'b0;
`endif

  assign pop  = not_empty & alu_in_ready;
  assign push = accept & legal & ~(byp & alu_in_ready);

  assign alu_in_valid = not_empty | byp;
  assign alu_in1      = byp ? req.in1 : head.in1;
  assign alu_in2      = byp ? req.in2 : head.in2;
  assign alu_op       = byp ? req.op  : head.op;
  assign count        = cnt;
  assign drop_cnt     = drops;

  alu_req_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (req),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // pointers and occupancy; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // saturating count of accepted illegal-op requests
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drops <= '0;
    end else if (accept & ~legal & (drops != '1)) begin
      drops <= drops + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_req_queue.sv
// Self-checking bench for alu_req_queue: vector table,
// directed corner cases and a random run vs a queue model.
module tb_alu_req_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int DMAX  = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_in1;
  logic [63:0] req_in2;
  logic [2:0]  req_op;
  logic [63:0] alu_in1;
  logic [63:0] alu_in2;
  logic [2:0]  alu_op;
  logic        alu_in_valid;
  logic        alu_in_ready;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  alu_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_in1      (req_in1),
    .req_in2      (req_in2),
    .req_op       (req_op),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_op       (alu_op),
    .alu_in_valid (alu_in_valid),
    .alu_in_ready (alu_in_ready),
    .count        (count),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
  } mreq_t;

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;
    logic        ev;
    logic [63:0] e1;
    logic [2:0]  eo;
    logic [2:0]  ec;
    logic        er;
  } vec_t;

  mreq_t       q[$];
  int          mdrop;
  logic [63:0] popped[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic bit is_legal(input logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
  endfunction

  function automatic bit bypass_on();
`ifdef ALU_REQ_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic rdy);
    req_valid    = v;
    req_op       = op;
    req_in1      = a;
    req_in2      = b;
    alu_in_ready = rdy;
  endtask

  // one clock: compare against model at negedge, then advance model
  task automatic cycle();
    bit    ev, byp, take, pop;
    mreq_t h;
    @(negedge clk);
    byp = bypass_on() && q.size() == 0 && req_valid
          && is_legal(req_op);
    ev  = (q.size() != 0) || byp;
    if (rstn) begin
      chk("m_valid", 64'(alu_in_valid), 64'(ev));
      chk("m_ready", 64'(req_ready), 64'(q.size() != DEPTH));
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_drop", 64'(drop_cnt), 64'(mdrop));
      if (ev) begin
        if (byp) begin
          h.a = req_in1; h.b = req_in2; h.op = req_op;
        end else begin
          h = q[0];
        end
        chk("m_in1", alu_in1, h.a);
        chk("m_in2", alu_in2, h.b);
        chk("m_op", 64'(alu_op), 64'(h.op));
      end
    end
    take = req_valid && q.size() < DEPTH;
    pop  = ev && alu_in_ready;
    if (pop) popped.push_back(alu_in1);
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      mdrop = 0;
      popped.delete();
    end else begin
      if (pop && !byp) void'(q.pop_front());
      if (take) begin
        if (!is_legal(req_op)) begin
          if (mdrop < DMAX) mdrop++;
        end else if (!(byp && alu_in_ready)) begin
          h.a = req_in1; h.b = req_in2; h.op = req_op;
          q.push_back(h);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  vec_t vt[8];

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    mdrop = 0;
    #1;
    do_reset();

    // reset then idle
    cycle();
    chk("rst_valid", 64'(alu_in_valid), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_in1", alu_in1, 64'(0));
    chk("rst_in2", alu_in2, 64'(0));
    chk("rst_op", 64'(alu_op), 64'(0));

`ifndef ALU_REQ_BYPASS_EN
    // single request and illegal-op drop, checked pre-edge
    vt[0] = '{1, 3'd0, 5, 3, 1, 0, 0, 0, 0, 1};
    vt[1] = '{0, 3'd0, 0, 0, 1, 1, 5, 0, 1, 1};
    vt[2] = '{0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 1};
    vt[3] = '{1, 3'd1, 9, 4, 0, 0, 0, 0, 0, 1};
    vt[4] = '{1, 3'd4, 1, 1, 0, 1, 9, 1, 1, 1};
    vt[5] = '{0, 3'd0, 0, 0, 0, 1, 9, 1, 1, 1};
    vt[6] = '{0, 3'd0, 0, 0, 1, 1, 9, 1, 1, 1};
    vt[7] = '{0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].vld, vt[i].op, vt[i].a, vt[i].b, vt[i].rdy);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(alu_in_valid),
          64'(vt[i].ev));
      chk($sformatf("v%0d_in1", i), alu_in1, vt[i].e1);
      chk($sformatf("v%0d_op", i), 64'(alu_op), 64'(vt[i].eo));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].ec));
      chk($sformatf("v%0d_ready", i), 64'(req_ready),
          64'(vt[i].er));
      cycle();
    end
    chk("tbl_drop", 64'(drop_cnt), 64'(1));
`endif

    // fill to DEPTH, 5th waits until a pop frees a slot
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 3'd0, 64'(k), 64'(k), 0);
      cycle();
    end
    chk("fill_count", 64'(count), 64'(4));
    chk("fill_ready", 64'(req_ready), 64'(0));
    popped.delete();
    drive(1, 3'd0, 5, 5, 0);
    cycle();
    chk("full_hold", 64'(count), 64'(4));
    drive(1, 3'd0, 5, 5, 1);
    cycle();
    chk("full_pop", 64'(count), 64'(3));
    cycle();
    chk("push5", 64'(count), 64'(3));
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle();
    chk("drain_n", 64'(popped.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < popped.size())
        chk($sformatf("drain_%0d", k), popped[k], 64'(k + 1));
    end

    // drop counter saturation
    drive(1, 3'd4, 0, 0, 1);
    for (int k = 0; k < 300; k++) cycle();
    chk("drop_sat", 64'(drop_cnt), 64'(255));

    // steady push/pop at count=2 across pointer wrap
    do_reset();
    drive(1, 3'd2, 100, 1, 0);
    cycle();
    drive(1, 3'd2, 101, 1, 0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, 3'd7, 64'(200 + k), 64'(k), 1);
      cycle();
      chk($sformatf("pp_count%0d", k), 64'(count), 64'(2));
    end
    drive(0, 0, 0, 0, 1);
    cycle();
    cycle();

    // reset with count=3 and an active handshake
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'd6, 64'(k), 64'(k), 0);
      cycle();
    end
    chk("pre_rst_cnt", 64'(count), 64'(3));
    rstn = 1'b0;
    drive(1, 3'd0, 7, 7, 1);
    cycle();
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("mrst_count", 64'(count), 64'(0));
    chk("mrst_valid", 64'(alu_in_valid), 64'(0));
    chk("mrst_in1", alu_in1, 64'(0));

`ifdef ALU_REQ_BYPASS_EN
    // zero-latency bypass while empty
    drive(1, 3'd2, 64'h55, 64'h0f, 1);
    #1;
    chk("byp_valid", 64'(alu_in_valid), 64'(1));
    chk("byp_in1", alu_in1, 64'h55);
    chk("byp_op", 64'(alu_op), 64'(2));
    cycle();
    chk("byp_count", 64'(count), 64'(0));
`endif

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rstn = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2) != 0);
      cycle();
    end
    rstn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
